// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
//   Shared constants, types and the digit-to-Morse encoder for the Morse
//   digit entry buffer.
//   CODE_W      : Morse symbols per stored code (bit4 plays first, 1 = dah)
//   DEPTH       : number of code slots held by the buffer
//   EMPTY_CODE  : value of an unused slot
//   edit_op_e   : decoded edit operation after priority resolution
//   digit_code  : BCD digit -> 5-symbol Morse code
//   digit_valid : digit is in 0..9
// ---------------------------------------------------------------------------
package morse_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned DEPTH  = 8;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t EMPTY_CODE = '0;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ENTER,
        OP_DEL,
        OP_CLR
    } edit_op_e;

    function automatic code_t digit_code(input logic [3:0] d);
        case (d)
            4'd0:    return 5'b11111;
            4'd1:    return 5'b01111;
            4'd2:    return 5'b00111;
            4'd3:    return 5'b00011;
            4'd4:    return 5'b00001;
            4'd5:    return 5'b00000;
            4'd6:    return 5'b10000;
            4'd7:    return 5'b11000;
            4'd8:    return 5'b11100;
            4'd9:    return 5'b11110;
            default: return EMPTY_CODE;
        endcase
    endfunction

    function automatic logic digit_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/morse_key_pulse.sv
// ---------------------------------------------------------------------------
// morse_key_pulse
//   Synchronises a raw key, debounces it and emits a single one-cycle pulse
//   once the key has been seen high for DB_CYCLES consecutive cycles. The key
//   must go low again before another pulse can be produced.
//   Parameters: DB_CYCLES - stable-high cycles required before accepting
//   Ports:
//     clk   in  system clock
//     rst   in  asynchronous active-high reset (discards any pending press)
//     key   in  raw key input
//     pulse out one-cycle accepted-press pulse (registered)
// ---------------------------------------------------------------------------
module morse_key_pulse #(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       key_sync;
    logic [CNT_W-1:0] cnt;
    logic             fired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sync <= '0;
            cnt      <= '0;
            fired    <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            key_sync <= {key_sync[0], key};
            pulse    <= 1'b0;
            if (!key_sync[1]) begin
                cnt   <= '0;
                fired <= 1'b0;
            end else if (!fired) begin
                // cnt holds the number of high samples already seen, so the
                // DB_CYCLES-th consecutive high sample is the one that fires.
                if (cnt == CNT_LAST) begin
                    pulse <= 1'b1;
                    fired <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morse_digit_buffer.sv
// ---------------------------------------------------------------------------
// morse_digit_buffer
//   Entry stage for the Morse buzzer player. Accepts BCD digits on a
//   debounced enter key, stores their Morse codes in order (r0 = first),
//   and supports delete-last and clear. Edits are ignored while lock is high.
//   Same-cycle priority: clr > del > enter; lower-priority pulses are dropped.
//   Optional build macro MORSE_OVERWRITE_EN: enter while full shifts the
//   buffer left and appends instead of raising err.
//   Parameters: DB_CYCLES - debounce length for every key
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     digit[3:0]      BCD digit sampled in the accept cycle
//     enter, del, clr raw keys
//     lock            playback running; edits ignored
//     r0..r7[4:0]     stored codes, unused slots zero
//     count[3:0]      number of stored codes 0..8
//     empty, full     count == 0 / count == 8
//     err             one-cycle pulse on a rejected edit
// ---------------------------------------------------------------------------
module morse_digit_buffer
    import morse_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       del,
    input  logic       clr,
    input  logic       lock,
    output logic [4:0] r0,
    output logic [4:0] r1,
    output logic [4:0] r2,
    output logic [4:0] r3,
    output logic [4:0] r4,
    output logic [4:0] r5,
    output logic [4:0] r6,
    output logic [4:0] r7,
    output logic [3:0] count,
    output logic       empty,
    output logic       full,
    output logic       err
);

    logic enter_p;
    logic del_p;
    logic clr_p;

    morse_key_pulse #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .key(enter), .pulse(enter_p)
    );
    morse_key_pulse #(.DB_CYCLES(DB_CYCLES)) u_del (
        .clk(clk), .rst(rst), .key(del), .pulse(del_p)
    );
    morse_key_pulse #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk(clk), .rst(rst), .key(clr), .pulse(clr_p)
    );

    edit_op_e   op;
    code_t      slots [DEPTH];
    code_t      new_code;
    logic [2:0] wr_idx;
    logic [2:0] last_idx;

    always_comb begin
        op = OP_NONE;
        if (!lock) begin
            if (clr_p)
                op = OP_CLR;
            else if (del_p)
                op = OP_DEL;
            else if (enter_p)
                op = OP_ENTER;
        end
    end

    assign new_code = digit_code(digit);
    assign wr_idx   = count[2:0];
    assign last_idx = count[2:0] - 3'd1;
    assign empty    = (count == 4'd0);
    assign full     = (count == 4'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= EMPTY_CODE;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (op)
                OP_CLR: begin
                    for (int unsigned i = 0; i < DEPTH; i++)
                        slots[i] <= EMPTY_CODE;
                    count <= '0;
                end
                OP_DEL: begin
                    if (empty) begin
                        err <= 1'b1;
                    end else begin
                        slots[last_idx] <= EMPTY_CODE;
                        count           <= count - 4'd1;
                    end
                end
                OP_ENTER: begin
                    if (!digit_valid(digit)) begin
                        err <= 1'b1;
                    end else if (!full) begin
                        slots[wr_idx] <= new_code;
                        count         <= count + 4'd1;
                    end else begin
`ifdef MORSE_OVERWRITE_EN
                        // Oldest code falls off r0; count stays at DEPTH.
                        for (int unsigned i = 0; i < DEPTH - 1; i++)
                            slots[i] <= slots[i+1];
                        slots[DEPTH-1] <= new_code;
`else
                        err <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign r0 = slots[0];
    assign r1 = slots[1];
    assign r2 = slots[2];
    assign r3 = slots[3];
    assign r4 = slots[4];
    assign r5 = slots[5];
    assign r6 = slots[6];
    assign r7 = slots[7];

endmodule

// File: tb/tb_morse_digit_buffer.sv
// ---------------------------------------------------------------------------
// tb_morse_digit_buffer
//   Table-driven directed bench for morse_digit_buffer (DB_CYCLES = 4) plus
//   hand-written sequences for glitch rejection, long holds, same-cycle
//   priority and reset during a pending press.
// ---------------------------------------------------------------------------
module tb_morse_digit_buffer;

    localparam logic [4:0] C0 = 5'b11111;
    localparam logic [4:0] C1 = 5'b01111;
    localparam logic [4:0] C2 = 5'b00111;
    localparam logic [4:0] C3 = 5'b00011;
    localparam logic [4:0] C4 = 5'b00001;
    localparam logic [4:0] C5 = 5'b00000;
    localparam logic [4:0] C6 = 5'b10000;
    localparam logic [4:0] C7 = 5'b11000;
    localparam logic [4:0] C8 = 5'b11100;
    localparam logic [4:0] C9 = 5'b11110;
    localparam logic [4:0] Z  = 5'b00000;

    localparam logic [2:0] K_ENTER = 3'b001;
    localparam logic [2:0] K_DEL   = 3'b010;
    localparam logic [2:0] K_CLR   = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit;
    logic       enter, del, clr, lock;
    logic [4:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [3:0] count;
    logic       empty, full, err;

    logic [39:0] r_all;
    assign r_all = {r0, r1, r2, r3, r4, r5, r6, r7};

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    always #5 clk = ~clk;

    morse_digit_buffer #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .digit(digit), .enter(enter), .del(del),
        .clr(clr), .lock(lock),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .count(count), .empty(empty), .full(full), .err(err)
    );

    // Counts cycles with err high, so a stuck err shows up as more than one.
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    typedef struct {
        string       name;
        logic [2:0]  keys;
        logic [3:0]  dig;
        logic        lk;
        int          exp_count;
        int          exp_err;
        logic [39:0] exp_r;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int ec, input int eerr,
                               input logic [39:0] er, input int err_before);
        check({tag, " count"}, 64'(count), 64'(ec));
        check({tag, " empty"}, 64'(empty), 64'(ec == 0));
        check({tag, " full"},  64'(full),  64'(ec == 8));
        check({tag, " regs"},  64'(r_all), 64'(er));
        check({tag, " err pulses"}, 64'(err_cnt - err_before), 64'(eerr));
    endtask

    task automatic press(input logic [2:0] keys, input logic [3:0] dig,
                         input logic lk, input int hold);
        @(negedge clk);
        digit = dig;
        lock  = lk;
        {clr, del, enter} = keys;
        repeat (hold) @(negedge clk);
        {clr, del, enter} = 3'b000;
        repeat (8) @(negedge clk);
        lock = 1'b0;
    endtask

    task automatic add(input string name, input logic [2:0] keys, input logic [3:0] dig,
                       input logic lk, input int ec, input int eerr, input logic [39:0] er);
        vec_t v;
        v.name = name; v.keys = keys; v.dig = dig; v.lk = lk;
        v.exp_count = ec; v.exp_err = eerr; v.exp_r = er;
        vecs.push_back(v);
    endtask

    initial begin
        int e0;
        logic [39:0] full8;

        full8 = {C3, C0, C9, C1, C2, C4, C6, C8};

        add("enter3", K_ENTER, 4'd3, 1'b0, 1, 0, {C3, Z, Z, Z, Z, Z, Z, Z});
        add("enter0", K_ENTER, 4'd0, 1'b0, 2, 0, {C3, C0, Z, Z, Z, Z, Z, Z});
        add("enter9", K_ENTER, 4'd9, 1'b0, 3, 0, {C3, C0, C9, Z, Z, Z, Z, Z});
        add("enter1", K_ENTER, 4'd1, 1'b0, 4, 0, {C3, C0, C9, C1, Z, Z, Z, Z});
        add("enter2", K_ENTER, 4'd2, 1'b0, 5, 0, {C3, C0, C9, C1, C2, Z, Z, Z});
        add("enter4", K_ENTER, 4'd4, 1'b0, 6, 0, {C3, C0, C9, C1, C2, C4, Z, Z});
        add("enter6", K_ENTER, 4'd6, 1'b0, 7, 0, {C3, C0, C9, C1, C2, C4, C6, Z});
        add("enter8", K_ENTER, 4'd8, 1'b0, 8, 0, full8);
`ifdef MORSE_OVERWRITE_EN
        full8 = {C0, C9, C1, C2, C4, C6, C8, C7};
        add("full_enter7", K_ENTER, 4'd7, 1'b0, 8, 0, full8);
`else
        add("full_enter7", K_ENTER, 4'd7, 1'b0, 8, 1, full8);
`endif
        add("full_enterA", K_ENTER, 4'hA, 1'b0, 8, 1, full8);
        add("clr",        K_CLR,   4'd0, 1'b0, 0, 0, '0);
        add("del_empty",  K_DEL,   4'd0, 1'b0, 0, 1, '0);
        add("enter2b",    K_ENTER, 4'd2, 1'b0, 1, 0, {C2, Z, Z, Z, Z, Z, Z, Z});
        add("enter7b",    K_ENTER, 4'd7, 1'b0, 2, 0, {C2, C7, Z, Z, Z, Z, Z, Z});
        add("del1",       K_DEL,   4'd0, 1'b0, 1, 0, {C2, Z, Z, Z, Z, Z, Z, Z});
        add("del2",       K_DEL,   4'd0, 1'b0, 0, 0, '0);
        add("del3_err",   K_DEL,   4'd0, 1'b0, 0, 1, '0);
        add("enterA",     K_ENTER, 4'hA, 1'b0, 0, 1, '0);
        add("lock_enter", K_ENTER, 4'd3, 1'b1, 0, 0, '0);
        add("enter5",     K_ENTER, 4'd5, 1'b0, 1, 0, {C5, Z, Z, Z, Z, Z, Z, Z});
        add("enter1b",    K_ENTER, 4'd1, 1'b0, 2, 0, {C5, C1, Z, Z, Z, Z, Z, Z});

        rst = 1'b1; digit = 4'd0; enter = 1'b0; del = 1'b0; clr = 1'b0; lock = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset", 0, 0, '0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            e0 = err_cnt;
            press(vecs[i].keys, vecs[i].dig, vecs[i].lk, 10);
            check_state(vecs[i].name, vecs[i].exp_count, vecs[i].exp_err, vecs[i].exp_r, e0);
        end

        // 3-cycle glitch on enter must not register
        e0 = err_cnt;
        press(K_ENTER, 4'd9, 1'b0, 3);
        check_state("glitch", 2, 0, {C5, C1, Z, Z, Z, Z, Z, Z}, e0);

        // long hold gives exactly one write
        e0 = err_cnt;
        press(K_ENTER, 4'd9, 1'b0, 20);
        check_state("hold20", 3, 0, {C5, C1, C9, Z, Z, Z, Z, Z}, e0);

        // clr and del together at count 5: clear wins, no err
        press(K_ENTER, 4'd4, 1'b0, 10);
        press(K_ENTER, 4'd6, 1'b0, 10);
        e0 = err_cnt;
        check_state("pre_clrdel", 5, 0, {C5, C1, C9, C4, C6, Z, Z, Z}, e0);
        press(K_CLR | K_DEL, 4'd0, 1'b0, 10);
        check_state("clr_del", 0, 0, '0, e0);

        // reset while enter is mid-debounce
        press(K_ENTER, 4'd1, 1'b0, 10);
        press(K_ENTER, 4'd2, 1'b0, 10);
        press(K_ENTER, 4'd3, 1'b0, 10);
        press(K_ENTER, 4'd4, 1'b0, 10);
        e0 = err_cnt;
        check_state("pre_rst", 4, 0, {C1, C2, C3, C4, Z, Z, Z, Z}, e0);
        @(negedge clk);
        digit = 4'd8;
        enter = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 0, 0, '0, e0);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_state("post_rst", 0, 0, '0, e0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
